// File: rtl/top.sv
// Name-prefix FIB lookup: hashes every prefix of a multi-word name, then walks a
// heap-indexed binary search tree once per prefix length, longest prefix first.
module top #(
   parameter int WORD_SIZE       = 64,
   parameter int POINTER_SIZE    = 16,
   parameter int MAX_NAME_LENGTH = 16,
   parameter int TREE_HEIGHT     = 4,
   localparam int LEN_W          = $clog2(MAX_NAME_LENGTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WORD_SIZE-1:0]    next_name_in [MAX_NAME_LENGTH],
   input  logic [LEN_W-1:0]        name_len_in,
   input  logic                    name_valid_in,
   output logic                    name_ready_out,
   input  logic                    wr_en,
   input  logic [TREE_HEIGHT-1:0]  wr_addr,
   input  logic [WORD_SIZE-1:0]    wr_key,
   input  logic [POINTER_SIZE-1:0] wr_face,
   input  logic                    wr_entry_valid,
   output logic                    result_valid,
   output logic                    result_hit,
   output logic [POINTER_SIZE-1:0] result_face,
   output logic [LEN_W-1:0]        result_prefix_len
);

   localparam int NODES = 2 ** TREE_HEIGHT;
   localparam int IDX_W = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;
   localparam int LVL_W = (TREE_HEIGHT > 1) ? $clog2(TREE_HEIGHT) : 1;

   typedef enum logic [1:0] {IDLE, HASH, SEARCH, DONE} state_t;

   state_t state, state_nxt;

   logic [WORD_SIZE-1:0]    tbl_key  [NODES];
   logic [POINTER_SIZE-1:0] tbl_face [NODES];
   logic [NODES-1:0]        tbl_vld;

   logic [WORD_SIZE-1:0]    name_q [MAX_NAME_LENGTH];
   logic [WORD_SIZE-1:0]    hash_q [MAX_NAME_LENGTH];
   logic [WORD_SIZE-1:0]    hash_c [MAX_NAME_LENGTH];
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        k_q;
   logic [LVL_W-1:0]        level_q;
   logic [TREE_HEIGHT-1:0]  idx_q;
   logic                    dead_q;
   logic                    found_q;
   logic [POINTER_SIZE-1:0] found_face_q;
   logic                    pend_hit_q;
   logic [POINTER_SIZE-1:0] pend_face_q;
   logic [LEN_W-1:0]        pend_len_q;

   logic [IDX_W-1:0]        kidx;
   logic [WORD_SIZE-1:0]    cur_hash;
   logic                    node_vld;
   logic [WORD_SIZE-1:0]    node_key;
   logic                    lvl_hit;
   logic                    hit_final;
   logic                    last_level;

   function automatic logic [WORD_SIZE-1:0] rotl5(input logic [WORD_SIZE-1:0] v);
      return {v[WORD_SIZE-6:0], v[WORD_SIZE-1:WORD_SIZE-5]};
   endfunction

   // Prefix hash chain: hash_c[k-1] covers words 0..k-1.
   always_comb begin
      logic [WORD_SIZE-1:0] acc;
      acc = '0;
      for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
         acc       = rotl5(acc) ^ name_q[i];
         hash_c[i] = acc;
      end
   end

   assign kidx       = IDX_W'(k_q - 1'b1);
   assign cur_hash   = hash_q[kidx];
   assign node_vld   = tbl_vld[idx_q];
   assign node_key   = tbl_key[idx_q];
   assign lvl_hit    = !dead_q && !found_q && node_vld && (node_key == cur_hash);
   assign hit_final  = found_q || lvl_hit;
   assign last_level = (level_q == LVL_W'(TREE_HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      name_ready_out = 1'b0;
      case (state)
         IDLE: begin
            name_ready_out = 1'b1;
            if (name_valid_in) state_nxt = HASH;
         end
         HASH:    state_nxt = (len_q == '0) ? DONE : SEARCH;
         SEARCH:  if (last_level && (hit_final || k_q == LEN_W'(1))) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Search datapath: one tree level per cycle, the walk always runs to full depth.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (name_valid_in) begin
               name_q <= next_name_in;
               len_q  <= (name_len_in > LEN_W'(MAX_NAME_LENGTH)) ? LEN_W'(MAX_NAME_LENGTH)
                                                                 : name_len_in;
            end
         end
         HASH: begin
            hash_q      <= hash_c;
            k_q         <= len_q;
            level_q     <= '0;
            idx_q       <= TREE_HEIGHT'(1);
            dead_q      <= 1'b0;
            found_q     <= 1'b0;
            pend_hit_q  <= 1'b0;
            pend_face_q <= '0;
            pend_len_q  <= '0;
         end
         SEARCH: begin
            if (!dead_q && !found_q) begin
               if (!node_vld) begin
                  dead_q <= 1'b1;
               end else if (node_key == cur_hash) begin
                  found_q      <= 1'b1;
                  found_face_q <= tbl_face[idx_q];
               end else begin
                  idx_q <= {idx_q[TREE_HEIGHT-2:0], !(cur_hash < node_key)};
               end
            end
            if (last_level) begin
               if (hit_final) begin
                  pend_hit_q  <= 1'b1;
                  pend_face_q <= found_q ? found_face_q : tbl_face[idx_q];
                  pend_len_q  <= k_q;
               end else if (k_q != LEN_W'(1)) begin
                  k_q     <= k_q - 1'b1;
                  level_q <= '0;
                  idx_q   <= TREE_HEIGHT'(1);
                  dead_q  <= 1'b0;
                  found_q <= 1'b0;
               end
            end else begin
               level_q <= level_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_addr != '0) begin
         tbl_key[wr_addr]  <= wr_key;
         tbl_face[wr_addr] <= wr_face;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tbl_vld           <= '0;
         result_valid      <= 1'b0;
         result_hit        <= 1'b0;
         result_face       <= '0;
         result_prefix_len <= '0;
      end else begin
         if (wr_en && wr_addr != '0) tbl_vld[wr_addr] <= wr_entry_valid;
         result_valid <= (state == DONE);
         if (state == DONE) begin
            result_hit        <= pend_hit_q;
            result_face       <= pend_face_q;
            result_prefix_len <= pend_len_q;
         end
      end
   end

endmodule

// File: tb/tb_top.sv
// Directed bench for the prefix FIB lookup: latency, hit/miss, clamping,
// concurrent writes and reset abort.
module tb_top;

   localparam int WS = 64;
   localparam int PS = 16;
   localparam int ML = 16;
   localparam int TH = 4;
   localparam int LW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [WS-1:0] next_name_in [ML];
   logic [LW-1:0] name_len_in = '0;
   logic          name_valid_in = 1'b0;
   logic          name_ready_out;
   logic          wr_en = 1'b0;
   logic [TH-1:0] wr_addr = '0;
   logic [WS-1:0] wr_key = '0;
   logic [PS-1:0] wr_face = '0;
   logic          wr_entry_valid = 1'b0;
   logic          result_valid;
   logic          result_hit;
   logic [PS-1:0] result_face;
   logic [LW-1:0] result_prefix_len;

   int checks = 0;
   int failures = 0;
   int lat;
   int stray;

   top #(.WORD_SIZE(WS), .POINTER_SIZE(PS), .MAX_NAME_LENGTH(ML), .TREE_HEIGHT(TH)) dut (
      .clk(clk), .rst_n(rst_n),
      .next_name_in(next_name_in), .name_len_in(name_len_in),
      .name_valid_in(name_valid_in), .name_ready_out(name_ready_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key), .wr_face(wr_face),
      .wr_entry_valid(wr_entry_valid),
      .result_valid(result_valid), .result_hit(result_hit),
      .result_face(result_face), .result_prefix_len(result_prefix_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int addr, input logic [63:0] key, input int face, input logic v);
      wr_en = 1'b1; wr_addr = TH'(addr); wr_key = key; wr_face = PS'(face); wr_entry_valid = v;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic set_name(input int len, input logic [63:0] w0, input logic [63:0] w1,
                           input logic [63:0] w2);
      for (int i = 0; i < ML; i++) next_name_in[i] = '0;
      next_name_in[0] = w0; next_name_in[1] = w1; next_name_in[2] = w2;
      name_len_in = LW'(len);
   endtask

   // Accept then count cycles until result_valid; returns 300 on timeout.
   task automatic lookup(input int len, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, output int latency);
      set_name(len, w0, w1, w2);
      name_valid_in = 1'b1;
      @(posedge clk); #1;
      name_valid_in = 1'b0;
      latency = 300;
      for (int c = 1; c < 300; c++) begin
         @(posedge clk); #1;
         if (result_valid) begin
            latency = c;
            break;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < ML; i++) next_name_in[i] = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", name_ready_out, 1);
      chk("rst_rvalid", result_valid, 0);
      chk("rst_hit", result_hit, 0);
      chk("rst_face", result_face, 0);
      chk("rst_plen", result_prefix_len, 0);
      rst_n = 1'b1;

      // Empty table, three prefixes tried
      lookup(3, 1, 2, 3, lat);
      chk("empty_lat", lat, 14);
      chk("empty_hit", result_hit, 0);
      chk("empty_plen", result_prefix_len, 0);

      // Oversized length clamps to 16 prefixes
      lookup(20, 0, 0, 0, lat);
      chk("clamp_lat", lat, 66);
      chk("clamp_hit", result_hit, 0);

      // Single root entry
      wr(1, 64'h1, 7, 1'b1);
      lookup(1, 1, 0, 0, lat);
      chk("root_lat", lat, 6);
      chk("root_hit", result_hit, 1);
      chk("root_face", result_face, 7);
      chk("root_plen", result_prefix_len, 1);
      @(posedge clk); #1;
      chk("pulse_once", result_valid, 0);
      chk("hold_face", result_face, 7);

      // Longer prefix absent, falls back to k=1
      lookup(2, 1, 2, 0, lat);
      chk("fb_lat", lat, 10);
      chk("fb_hit", result_hit, 1);
      chk("fb_face", result_face, 7);
      chk("fb_plen", result_prefix_len, 1);

      // Zero length: busy handshake, second request ignored
      set_name(0, 0, 0, 0);
      name_valid_in = 1'b1;
      @(posedge clk); #1;
      chk("z_busy0", name_ready_out, 0);
      set_name(3, 1, 2, 3);
      @(posedge clk); #1;
      chk("z_busy1", name_ready_out, 0);
      chk("z_novalid", result_valid, 0);
      name_valid_in = 1'b0;
      @(posedge clk); #1;
      chk("z_valid", result_valid, 1);
      chk("z_hit", result_hit, 0);
      chk("z_face", result_face, 0);
      chk("z_plen", result_prefix_len, 0);
      chk("z_ready", name_ready_out, 1);

      // Left descent: 0x22 < 0x100
      wr(1, 64'h100, 3, 1'b1);
      wr(2, 64'h22, 9, 1'b1);
      lookup(2, 1, 2, 0, lat);
      chk("left_lat", lat, 6);
      chk("left_hit", result_hit, 1);
      chk("left_face", result_face, 9);
      chk("left_plen", result_prefix_len, 2);

      // Right descent: 0x22 > 0x10
      wr(1, 64'h10, 3, 1'b1);
      wr(3, 64'h22, 11, 1'b1);
      lookup(2, 1, 2, 0, lat);
      chk("right_lat", lat, 6);
      chk("right_face", result_face, 11);
      chk("right_plen", result_prefix_len, 2);

      // Invalidated node ends walk; k=1 reaches unwritten node 4
      wr(3, 64'h22, 11, 1'b0);
      lookup(2, 1, 2, 0, lat);
      chk("inv_lat", lat, 10);
      chk("inv_hit", result_hit, 0);
      chk("inv_face", result_face, 0);

      // Write landing during HASH is seen by the walk
      set_name(1, 5, 0, 0);
      name_valid_in = 1'b1;
      @(posedge clk); #1;
      name_valid_in = 1'b0;
      wr(1, 64'h5, 4, 1'b1);
      lat = 300;
      for (int c = 2; c < 40; c++) begin
         @(posedge clk); #1;
         if (result_valid) begin
            lat = c;
            break;
         end
      end
      chk("inflt_lat", lat, 6);
      chk("inflt_hit", result_hit, 1);
      chk("inflt_face", result_face, 4);

      // Reset mid-search
      lookup_start: begin
         set_name(3, 5, 0, 0);
         name_valid_in = 1'b1;
         @(posedge clk); #1;
         name_valid_in = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 30; c++) begin
         if (result_valid) stray++;
         @(posedge clk); #1;
      end
      chk("abort_nopulse", stray, 0);
      chk("abort_hit", result_hit, 0);
      chk("abort_face", result_face, 0);
      lookup(1, 5, 0, 0, lat);
      chk("post_rst_lat", lat, 6);
      chk("post_rst_hit", result_hit, 0);
      chk("post_rst_plen", result_prefix_len, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 64, width of one name component word and of hash keys.
REQ-002 The module SHALL have parameter POINTER_SIZE, default 16, width of the face id stored per FIB entry.
REQ-003 The module SHALL have parameter MAX_NAME_LENGTH, default 16, maximum name length in words.
REQ-004 The module SHALL have parameter TREE_HEIGHT, default 4 (instantiated as 4), number of BST levels; the table holds 2^TREE_HEIGHT-1 nodes.
REQ-005 The module SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 next_name_in  input  MAX_NAME_LENGTH x WORD_SIZE unpacked array  name components; word 0 is the first component.
REQ-009 name_len_in  input  $clog2(MAX_NAME_LENGTH+1)  number of valid words, 0..MAX_NAME_LENGTH.
REQ-010 name_valid_in / name_ready_out  input / output  1 each  lookup request handshake.
REQ-011 wr_en, wr_addr[TREE_HEIGHT-1:0], wr_key[WORD_SIZE-1:0], wr_face[POINTER_SIZE-1:0], wr_entry_valid  inputs  table write port; wr_addr is a 1-based heap index.
REQ-012 result_valid, result_hit (1 bit each), result_face[POINTER_SIZE-1:0], result_prefix_len (width of name_len_in)  outputs  lookup result.

Function
REQ-013 Prefix hash SHALL be h0=0, hk = rotate_left(h(k-1),5) XOR word[k-1], computed over WORD_SIZE bits.
REQ-014 The table SHALL be a heap-indexed BST: node i has children 2i and 2i+1; node 1 is root; each node holds key, face and entry-valid bit.
REQ-015 A request SHALL be accepted on a rising edge where name_valid_in=1 and name_ready_out=1; the name and length are captured into internal registers at that edge.
REQ-016 name_ready_out SHALL be 1 only in IDLE; states: IDLE -> HASH (1 cycle, computes all prefix hashes) -> SEARCH -> DONE -> IDLE.
REQ-017 SEARCH SHALL try prefix lengths k = name_len down to 1; each k takes exactly TREE_HEIGHT cycles, one tree level per cycle, with no early exit inside a level walk.
REQ-018 Per level: invalid node -> miss for this k; key equal -> hit; hk < key -> left child; else right child; comparison is unsigned.
REQ-019 The first k that hits SHALL end SEARCH; result_hit=1, result_face=node face, result_prefix_len=k.
REQ-020 If all k miss, or name_len=0 (HASH goes directly to DONE), result_hit=0, result_face=0, result_prefix_len=0.
REQ-021 In DONE result_valid SHALL be 1 for exactly one cycle; result fields SHALL hold until the next result.
REQ-022 Latency from accept edge to result_valid high = 1 + TREE_HEIGHT*(number of prefixes tried) + 1 cycles.
REQ-023 name_len_in > MAX_NAME_LENGTH SHALL be clamped to MAX_NAME_LENGTH.
REQ-024 Table writes SHALL be accepted every cycle regardless of state; wr_addr=0 SHALL be ignored; a write is visible to lookup reads from the next cycle, including in-flight searches.

Reset
REQ-025 On rst_n=0 at a rising edge: state=IDLE, all entry-valid bits=0, result_valid=0, result_hit=0, result_face=0, result_prefix_len=0; name_ready_out=1 from the first cycle after reset.
REQ-026 Reset during HASH/SEARCH SHALL abort the lookup with no result_valid pulse.

Verification
REQ-027 Write node1 {key=1, face=7, valid}; lookup len=1, word0=1 -> result_valid 6 cycles after accept, hit=1, face=7, prefix_len=1.
REQ-028 Same table; lookup len=2, words {1,2} (h2=0x22, absent) -> k=2 miss, k=1 hit; face=7, prefix_len=1, latency 10 cycles.
REQ-029 Empty table, lookup len=3 -> hit=0, face=0, prefix_len=0, latency 1+12+1=14 cycles.
REQ-030 Lookup len=0 -> hit=0 after 2 cycles; name_ready_out=0 between accept and DONE, name_valid_in ignored while busy.
REQ-031 Nodes 1 {key=0x100}, 2 {key=0x22, face=9}; lookup {1,2} -> walk root then left, hit face=9, prefix_len=2.
REQ-032 Assert rst_n=0 mid-SEARCH -> no result_valid pulse, all table entries invalid, next lookup misses.
